// File: rtl/idle_rate_match.sv
// 64b/66b elastic buffer. It deletes idle blocks when the buffer runs high and inserts idles when it runs low,
// and it emits a loss-of-sync block when a pull finds the buffer empty.
module idle_rate_match #(
  parameter int          DEPTH     = 16,
  parameter int          HIGH_MARK = 12,
  parameter int          LOW_MARK  = 4,
  parameter logic [7:0]  IDLE_TYPE = 8'h1E,
  parameter int          CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              in_dat,
  input  logic [1:0]               in_sh,
  input  logic                     in_val,
  input  logic                     rm_en,
  input  logic                     out_rdy,
  output logic [63:0]              out_dat,
  output logic [1:0]               out_sh,
  output logic                     out_val,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         ins_cnt,
  output logic [CNT_W-1:0]         del_cnt,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         unf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] HIGH_L  = LW'(HIGH_MARK);
  localparam logic [LW-1:0] LOW_L   = LW'(LOW_MARK);
  localparam logic [65:0]   IDLE_BLK = {2'b01, 56'h0, IDLE_TYPE};

  // Handshake: in_val has no back-pressure, so the buffer accepts, deletes or drops a block in the same cycle.
  // out_rdy is a pull strobe: every cycle with out_rdy loads exactly one block into out_*, and out_val flags that load one cycle later.

  logic [65:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          prev_in_idle, last_out_idle, ins_prev;

  logic          in_idle, del, wr_try, full, wr, drop;
  logic          ins, pop, unf;
  logic [65:0]   rd_blk;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c,
                                            input logic ev, input logic clr);
    if (clr) return '0;
    if (ev && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  always_comb begin
    in_idle = (in_sh == 2'b01) && (in_dat[7:0] == IDLE_TYPE);
    del     = rm_en && in_val && in_idle && prev_in_idle && (level >= HIGH_L);
    wr_try  = in_val && !del;
    full    = (level == DEPTH_L);
    // Insertions never occur back-to-back. This guarantees that residual entries always drain.
    ins     = out_rdy && rm_en && last_out_idle && !ins_prev && (level <= LOW_L);
    pop     = out_rdy && !ins && (level != '0);
    unf     = out_rdy && !ins && (level == '0);
    // A pop in the same cycle frees a slot, so a full buffer can still accept the block.
    wr      = wr_try && (!full || pop);
    drop    = wr_try && full && !pop;
    if (ins)      rd_blk = IDLE_BLK;
    else if (pop) rd_blk = mem[rd_ptr];
    else          rd_blk = '0;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {in_sh, in_dat};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      prev_in_idle  <= 1'b0;
      last_out_idle <= 1'b0;
      ins_prev      <= 1'b0;
      out_dat       <= '0;
      out_sh        <= '0;
      out_val       <= 1'b0;
      ovf           <= 1'b0;
      ins_cnt       <= '0;
      del_cnt       <= '0;
      ovf_cnt       <= '0;
      unf_cnt       <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      level <= level + 1'b1;
      else if (pop && !wr) level <= level - 1'b1;
      if (in_val) prev_in_idle <= in_idle;
      out_val <= out_rdy;
      if (out_rdy) begin
        ins_prev      <= ins;
        {out_sh, out_dat} <= rd_blk;
        last_out_idle <= (rd_blk[65:64] == 2'b01) && (rd_blk[7:0] == IDLE_TYPE);
      end
      if (clr_stats) ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
      ins_cnt <= bump(ins_cnt, ins,  clr_stats);
      del_cnt <= bump(del_cnt, del,  clr_stats);
      ovf_cnt <= bump(ovf_cnt, drop, clr_stats);
      unf_cnt <= bump(unf_cnt, unf,  clr_stats);
    end
  end
endmodule

// File: doc/idle_rate_match.md
# idle_rate_match

Single-clock, parametrised 64b/66b elastic buffer that absorbs bursty block arrival and rate-matches against a downstream pull strobe. Idle control blocks (sync header 01, block type IDLE_TYPE) are deleted on write when the buffer is high and inserted on read when it is low. The block drives a loss-of-sync pattern when starved, supports a bypass mode and keeps saturating event counters. It sits between the receive-side block aligner and the transmit encoder/BIST mux.

## Interface
- DEPTH, 16: FIFO entries, power of 2, 8..256.
- HIGH_MARK, 12: delete idles when level >= HIGH_MARK.
- LOW_MARK, 4: insert idles when level <= LOW_MARK; must be < HIGH_MARK.
- IDLE_TYPE, 8'h1E: block type byte dat[7:0] identifying an idle block.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_dat  in  64  input block payload.
- in_sh  in  2  input sync header.
- in_val  in  1  input block valid.
- rm_en  in  1  1 = rate matching on; 0 = bypass, plain FIFO with no insert/delete.
- out_rdy  in  1  downstream pulls one block this cycle.
- out_dat  out  64  output payload.
- out_sh  out  2  output sync header.
- out_val  out  1  output block valid.
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky overflow flag.
- clr_stats  in  1  synchronous clear of counters and ovf.
- ins_cnt, del_cnt, ovf_cnt, unf_cnt  out  CNT_W each  saturating event counters.

## Operation
- Idle block: sh == 2'b01 and dat[7:0] == IDLE_TYPE.
- prev_in_idle: set to the idle status of each in_val block presented, including deleted ones. Reset value 0.
- Delete: rm_en=1, in_val=1, block is idle, prev_in_idle=1, level >= HIGH_MARK. The block is not written and del_cnt increments. The first idle of a run is never deleted.
- Write: in_val=1 and not deleted. If level == DEPTH and no read occurs this cycle, the block is dropped, ovf_cnt increments and ovf is set. A simultaneous read frees the slot, so no drop occurs.
- last_out_idle: set when the output register is loaded with an idle block, cleared on a non-idle or LOS load. Reset value 0.
- ins_prev: 1 if the previous pull was an insertion. Reset value 0.
- Read: each out_rdy cycle selects exactly one action, in this priority:
  - Insert: rm_en=1, last_out_idle=1, ins_prev=0, level <= LOW_MARK. Load {sh=01, dat={56'h0, IDLE_TYPE}}, no pop, ins_cnt increments. Insertions never occur back-to-back, so residual data always drains.
  - Pop: level > 0. Load the head entry.
  - Underflow: level == 0. Load LOS {sh=00, dat=0}, unf_cnt increments.
- out_val: registered copy of out_rdy. Output holds its value on cycles without out_rdy.
- level: +1 on write, -1 on pop, unchanged when both or neither occur.
- Counters: saturate at all-ones. clr_stats zeroes all counters and ovf, and wins over a same-cycle increment.
- rm_en change: takes effect on the next cycle's decisions. FIFO contents are preserved.

## Timing
- Reset values: out_dat=0, out_sh=0, out_val=0, level=0, ovf=0, all counters 0, FIFO empty, flags 0.
- Reset asserted mid-operation clears everything asynchronously. FIFO contents are discarded.
- Latency: block written at edge N counts in level after N. If out_rdy is high in cycle N+1, the block appears on out_* after edge N+1, i.e. 2 cycles input-to-output.
- Memory read is combinational from the head entry. out_* are registered.
- Delete and insert decisions use level as registered at the start of the cycle.
- Pointers wrap modulo DEPTH. level distinguishes full (DEPTH) from empty (0).

## Test plan
- Reset, then 10 data blocks (sh=10) with out_rdy held 1: output shows LOS, then each block 2 cycles after input, in order. unf_cnt counts only the starved pulls.
- Fill to level 12 with out_rdy=0, then present three idles: first idle written, second and third deleted. del_cnt=2, level=13.
- Level 3, last output idle, out_rdy=1, no input: outputs alternate inserted idle / popped block. ins_cnt increments every second pull and level reaches 0 without stalling.
- Fill to 16 with out_rdy=0, then present one more data block: dropped, ovf=1, ovf_cnt=1. Repeat with out_rdy=1: not dropped, level stays 16.
- rm_en=0, repeat the delete and insert scenarios: no deletions or insertions, del_cnt=ins_cnt=0, idles pass through unchanged.
- Force unf_cnt to all-ones via prolonged starvation (CNT_W=4 build): counter holds 15. clr_stats with a simultaneous underflow leaves 0.
